// File: rtl/simon_pkg.sv
// Shared widths, state encoding and record types for the SIMON pipeline scheduler.
package simon_pkg;
    localparam int SIMON_LAT = 32;
    localparam int BLK_W     = 32;
    localparam int KEY_W     = 64;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD
    } sched_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    typedef struct packed {
        logic             id;
        logic [BLK_W-1:0] data;
    } rsp_t;
endpackage

// File: rtl/simon_res_fifo.sv
// Result buffer: first-word-fall-through FIFO whose head word and valid flag are registers.
module simon_res_fifo
    import simon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = $bits(rsp_t)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i & valid_q;
    assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        valid_d  = (count_d != '0);
        data_d   = '0;
        if (count_d != '0) begin
            // The word being written this edge becomes the head when nothing else remains.
            if ((count_q - CW'(do_pop)) == '0) data_d = push_data_i;
            else                              data_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which words are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;
endmodule

// File: rtl/simon_pipe_sched.sv
// Round-robin issue of two requesters into an external SIMON pipeline, with in-order result return and key reload.
module simon_pipe_sched
    import simon_pkg::*;
#(
    parameter int LAT        = SIMON_LAT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [BLK_W-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [BLK_W-1:0] req1_data,
    output logic             req1_ready,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_data,
    output logic             key_ready,
    output logic [BLK_W-1:0] pipe_pt,
    output logic [KEY_W-1:0] pipe_key,
    input  logic [BLK_W-1:0] pipe_ct,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BLK_W-1:0] rsp_data,
    output logic             rsp_id
);
    localparam int IW = $clog2(LAT+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int SW = ((IW > CW) ? IW : CW) + 1;

    sched_state_e     state_q;
    logic [KEY_W-1:0] key_q;
    logic             key_ready_q;
    logic             rr_q;
    tag_t             tag_q [LAT];
    logic [IW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    fifo_count;
    logic [SW-1:0]    used;
    logic             can_issue, grant0, grant1, grant, tag_exit;
    rsp_t             fifo_in, fifo_out;

    // Credit covers both in-flight blocks and buffered results, so the FIFO can never overflow.
    assign used      = SW'(inflight_q) + SW'(fifo_count);
    assign can_issue = rst & (state_q == ST_RUN) & ~key_valid & (used < SW'(FIFO_DEPTH));
    assign grant0    = can_issue & req0_valid & (~req1_valid | ~rr_q);
    assign grant1    = can_issue & req1_valid & (~req0_valid | rr_q);
    assign grant     = grant0 | grant1;
    assign tag_exit  = tag_q[LAT-1].valid;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign key_ready  = key_ready_q;
    assign pipe_key   = key_q;

    always_comb begin
        pipe_pt = '0;
        if (grant0)      pipe_pt = req0_data;
        else if (grant1) pipe_pt = req1_data;
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({grant, tag_exit})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
            inflight_q <= '0;
            rr_q       <= 1'b0;
        end else begin
            tag_q[0] <= '{valid: grant, id: grant1};
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
            inflight_q <= inflight_d;
            if (grant0)      rr_q <= 1'b1;
            else if (grant1) rr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            key_q       <= '0;
            key_ready_q <= 1'b0;
        end else begin
            key_ready_q <= 1'b0;
            case (state_q)
                ST_RUN: if (key_valid) state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    if (key_valid && (inflight_q == '0)) begin
                        state_q     <= ST_LOAD;
                        key_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    key_q   <= key_data;
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign fifo_in = '{id: tag_q[LAT-1].id, data: pipe_ct};

    simon_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(rsp_t))
    ) u_res_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tag_exit),
        .push_data_i (fifo_in),
        .pop_i       (rsp_ready),
        .valid_o     (rsp_valid),
        .data_o      (fifo_out),
        .count_o     (fifo_count)
    );

    assign rsp_data = fifo_out.data;
    assign rsp_id   = fifo_out.id;
endmodule

// File: tb/tb_simon_pipe_sched.sv
// Directed bench for simon_pipe_sched with a behavioural SIMON 32/64 pipeline standing in for the real core.
module tb_simon_pipe_sched;
    import simon_pkg::*;

    localparam int LAT   = 12;
    localparam int DEPTH = 16;
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic        key_valid, key_ready;
    logic [63:0] key_data;
    logic [31:0] pipe_pt, pipe_ct;
    logic [63:0] pipe_key;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          rsp_at_pulse = 0;
    logic [63:0] tb_key = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simon_pipe_sched #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
        .pipe_pt(pipe_pt), .pipe_key(pipe_key), .pipe_ct(pipe_ct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [31:0] simon_enc(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] x, y, tmp;
        logic [61:0] z;
        z = Z0;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            tmp  = ror16(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror16(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    // External pipeline: pt/key sampled at an edge, ciphertext presented LAT cycles later.
    logic [31:0] ct_pipe [LAT];
    always @(posedge clk) begin
        ct_pipe[0] <= simon_enc(pipe_pt, pipe_key);
        for (int i = 1; i < LAT; i++) ct_pipe[i] <= ct_pipe[i-1];
    end
    assign pipe_ct = ct_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard: every grant queues its expected result under the bench's key; responses must match in order.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (req0_ready || req1_ready) check("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (req0_ready) exp_q.push_back('{1'b0, simon_enc(req0_data, tb_key)});
            if (req1_ready) exp_q.push_back('{1'b1, simon_enc(req1_data, tb_key)});
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                check("rsp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                    check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !rsp_valid;
            tick();
        end
        check(name, {63'd0, done}, 64'd1);
    endtask

    // Ends at the negedge of the first RUN cycle after the load, without advancing past it.
    task automatic load_key(input logic [63:0] k);
        bit seen = 1'b0;
        int grants = 0;
        key_valid = 1'b1;
        key_data  = k;
        for (int i = 0; i < 4 * LAT && !seen; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) grants++;
            if (key_ready) begin
                seen         = 1'b1;
                tb_key       = k;
                rsp_at_pulse = rsp_cnt;
            end
            tick();
        end
        key_valid = 1'b0;
        key_data  = ~k;
        check("key_ready_seen", {63'd0, seen}, 64'd1);
        check("no_grant_in_keychg", 64'(grants), 64'd0);
        @(negedge clk);
        check("key_ready_pulse", {63'd0, key_ready}, 64'd0);
        check("pipe_key_loaded", pipe_key, k);
    endtask

    typedef struct {
        logic r0v, r1v, e0, e1;
    } vec_t;
    vec_t vecs[12];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g, r, grants, c0, cnt;
        bit found;
        logic [31:0] d0, d1, ept, got_data;
        logic got_id;
        logic exp_id;

        vecs[0]  = '{0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0};
        vecs[2]  = '{1, 0, 1, 0};
        vecs[3]  = '{1, 1, 0, 1};
        vecs[4]  = '{1, 1, 1, 0};
        vecs[5]  = '{0, 1, 0, 1};
        vecs[6]  = '{0, 1, 0, 1};
        vecs[7]  = '{1, 1, 1, 0};
        vecs[8]  = '{0, 0, 0, 0};
        vecs[9]  = '{1, 1, 0, 1};
        vecs[10] = '{1, 0, 1, 0};
        vecs[11] = '{1, 1, 0, 1};

        // Reset: outputs quiet even with requests pending.
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'h1111_1111; req1_data = 32'h2222_2222;
        key_valid = 1'b0; key_data = 64'h0123_4567_89ab_cdef;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
        check("rst_key_ready", {63'd0, key_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        check("rst_pipe_pt", {32'd0, pipe_pt}, 64'd0);
        check("rst_pipe_key", pipe_key, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Arbitration table.
        for (int i = 0; i < 12; i++) begin
            d0 = 32'hA000_0000 + i;
            d1 = 32'hB000_0000 + i;
            req0_valid = vecs[i].r0v; req1_valid = vecs[i].r1v;
            req0_data = d0; req1_data = d1;
            ept = vecs[i].e0 ? d0 : (vecs[i].e1 ? d1 : 32'd0);
            @(negedge clk);
            check("tbl_req0_ready", {63'd0, req0_ready}, {63'd0, vecs[i].e0});
            check("tbl_req1_ready", {63'd0, req1_ready}, {63'd0, vecs[i].e1});
            check("tbl_pipe_pt", {32'd0, pipe_pt}, {32'd0, ept});
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain("drain_table");

        // Known-answer block and grant-to-response latency.
        load_key(64'h1918_1110_0908_0100);
        tick();
        req0_valid = 1'b1; req0_data = 32'h6565_6877;
        @(negedge clk);
        check("kat_grant", {63'd0, req0_ready}, 64'd1);
        g = cyc;
        tick();
        req0_valid = 1'b0;
        found = 1'b0; r = 0; got_data = '0; got_id = 1'b1;
        for (int i = 0; i < 3 * LAT && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1; r = cyc; got_data = rsp_data; got_id = rsp_id;
            end
            tick();
        end
        check("kat_rsp_seen", {63'd0, found}, 64'd1);
        check("kat_latency", 64'(r - g), 64'(LAT + 1));
        check("kat_ct", {32'd0, got_data}, 64'h0000_0000_c69b_e9bb);
        check("kat_id", {63'd0, got_id}, 64'd0);
        wait_drain("drain_kat");

        // Both requesters continuously valid: strict alternation, pointer currently at requester 1.
        exp_id = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req0_data = 32'hC000_0000 + i;
            req1_data = 32'hD000_0000 + i;
            @(negedge clk);
            check("alt_req0_ready", {63'd0, req0_ready}, {63'd0, exp_id == 1'b0});
            check("alt_req1_ready", {63'd0, req1_ready}, {63'd0, exp_id == 1'b1});
            exp_id = ~exp_id;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain("drain_alt");

        // Back-pressure: exactly DEPTH grants, then stall until results are consumed.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        grants = 0;
        c0 = rsp_cnt;
        for (int i = 0; i < 40; i++) begin
            req0_data = 32'hE000_0000 + i;
            req1_data = 32'hF000_0000 + i;
            @(negedge clk);
            grants += int'(req0_ready) + int'(req1_ready);
            tick();
        end
        check("full_grants", 64'(grants), 64'(DEPTH));
        @(negedge clk);
        check("full_stall", {63'd0, req0_ready | req1_ready}, 64'd0);
        check("full_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        tick();
        rsp_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) found = 1'b1;
            tick();
        end
        check("issue_resumes", {63'd0, found}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain("drain_full");
        check("full_returned", {63'd0, (rsp_cnt - c0) >= DEPTH}, 64'd1);

        // Key change with five blocks in flight.
        c0 = rsp_cnt;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_data = 32'h0BAD_0000 + i;
            @(negedge clk);
            check("old_key_grant", {63'd0, req0_ready}, 64'd1);
            tick();
        end
        req0_data = 32'h600D_F00D;
        load_key(64'h0F0E_0D0C_0B0A_0908);
        check("old_results_first", 64'(rsp_at_pulse - c0), 64'd5);
        check("new_key_grant", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        found = 1'b0; got_data = '0;
        for (int i = 0; i < 3 * LAT && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1; got_data = rsp_data;
            end
            tick();
        end
        check("new_key_rsp_seen", {63'd0, found}, 64'd1);
        check("new_key_ct", {32'd0, got_data}, {32'd0, simon_enc(32'h600D_F00D, 64'h0F0E_0D0C_0B0A_0908)});
        wait_drain("drain_key");

        // Reset with 3 results buffered and 10 blocks in flight.
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_data = 32'h3000_0000 + i;
            tick();
        end
        req0_valid = 1'b0;
        repeat (LAT + 3) tick();
        @(negedge clk);
        check("buffered_before_rst", {63'd0, rsp_valid}, 64'd1);
        tick();
        req0_valid = 1'b1;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            req0_data = 32'h4000_0000 + i;
            @(negedge clk);
            grants += int'(req0_ready);
            tick();
        end
        check("inflight_grants", 64'(grants), 64'd10);
        req1_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("midrst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("midrst_ready", {63'd0, req0_ready | req1_ready}, 64'd0);
        check("midrst_pipe_pt", {32'd0, pipe_pt}, 64'd0);
        repeat (3) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        tb_key = '0;
        rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
            tick();
        end
        check("no_rsp_after_rst", 64'(cnt), 64'd0);
        check("pipe_key_after_rst", pipe_key, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/simon_pipe_sched.md
SIMON_PIPE_SCHED -- requirements
Module: simon_pipe_sched

Interface
REQ-001 SHALL have parameter LAT, default 32: cycles from pipe_pt sampled to matching pipe_ct valid.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: result buffer entries, power of two, >= 2.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 block pending.
REQ-006 req0_data / req1_data  in  32  requester 0/1 plaintext.
REQ-007 req0_ready / req1_ready  out  1  block accepted this cycle.
REQ-008 key_valid  in  1  key change request; key_data  in  64  new key.
REQ-009 key_ready  out  1  one-cycle pulse when key_data is latched.
REQ-010 pipe_pt  out  32  plaintext to simon_pipeline; pipe_key  out  64  key to simon_pipeline.
REQ-011 pipe_ct  in  32  ciphertext from simon_pipeline.
REQ-012 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  32; rsp_id  out  1 (originating requester).

Function
REQ-013 States: RUN, DRAIN, LOAD; reset enters RUN.
REQ-014 Issue in RUN only, when key_valid=0 and inflight + fifo_count < FIFO_DEPTH (credit).
REQ-015 Grant: round-robin; sole valid requester wins; both valid -> pointer side wins; pointer moves to the other requester after each grant.
REQ-016 reqN_ready high only for granted requester; at most one ready per cycle; ready may depend on valid.
REQ-017 Granted data drives pipe_pt combinationally; no grant -> pipe_pt = 0.
REQ-018 Tag shift register, LAT stages of {valid, id}; grant pushes {1, id}, else {0, x}.
REQ-019 Tag exiting stage LAT with valid=1 -> pipe_ct and id written to FIFO same edge.
REQ-020 inflight = count of valid tags; width clog2(LAT+1); +1 on grant, -1 on exit, unchanged on both.
REQ-021 FIFO: registered outputs; rsp_valid = not empty; pop on rsp_valid & rsp_ready; simultaneous push/pop keeps count; credit rule guarantees no push when full (overflow never occurs).
REQ-022 Latency: grant at edge N -> rsp_valid at edge N+LAT+1 if FIFO was empty.
REQ-023 Responses leave in grant order.
REQ-024 key_valid in RUN -> DRAIN; no grants from that cycle (key beats requests in same cycle).
REQ-025 DRAIN -> LOAD when inflight = 0; FIFO contents need not drain.
REQ-026 LOAD: key_ready=1, key register <= key_data, -> RUN next cycle; LOAD lasts exactly one cycle.
REQ-027 pipe_key = key register; constant in RUN, therefore all in-flight blocks use one key.
REQ-028 key_valid deasserted during DRAIN: remain in DRAIN, complete load on next key_valid (key_valid must hold until key_ready).

Reset
REQ-029 rst low: state RUN, key register 0, tags cleared, inflight 0, FIFO empty, round-robin pointer 0.
REQ-030 Outputs during reset: reqN_ready 0, key_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, pipe_pt 0, pipe_key 0.
REQ-031 Reset mid-operation discards in-flight blocks and buffered results; none appear after release.

Structure
REQ-032 Package simon_pkg: SIMON_LAT=32, block width 32, key width 64, state enum.
REQ-033 One sub-module simon_res_fifo (33-bit data+id, parametrised depth, count output).
REQ-034 simon_pipeline instantiated outside; connected via pipe_* ports.

Verification
REQ-035 Load key 64'h1918111009080100, req0 pt 32'h65656877 -> rsp_data 32'hc69be9bb, rsp_id 0, LAT+1 cycles after grant.
REQ-036 Both requesters valid continuously, rsp_ready=1 -> grants 0,1,0,1...; one grant per cycle; rsp_id alternates in order.
REQ-037 rsp_ready=0, both valid -> exactly FIFO_DEPTH grants, then ready low; raise rsp_ready -> all 8 returned in order, issue resumes.
REQ-038 Key change with 5 blocks in flight -> no grant until inflight 0; 5 old-key results precede; key_ready single pulse; next block uses new key.
REQ-039 rst low with 10 in flight and 3 buffered -> rsp_valid 0 immediately; after release no response without a new grant.
